// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: shared types and March C- table for the 1RW memory BIST
package mem_bist_pkg;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

   localparam int ELEM_W    = 3;
   localparam int NUM_ELEMS = 6;
   localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(NUM_ELEMS - 1);

   typedef struct packed {
      logic desc;
      logic has_read;
      logic read_val;
      logic has_write;
      logic write_val;
   } march_t;

   // {desc, has_read, read_val, has_write, write_val}
   localparam march_t MARCH [NUM_ELEMS] = '{
      5'b00010,  // up   (w0)
      5'b01011,  // up   (r0,w1)
      5'b01110,  // up   (r1,w0)
      5'b11011,  // down (r0,w1)
      5'b11110,  // down (r1,w0)
      5'b01000   // up   (r0)
   };

   // Past the last element every field reads as 0, so the sequencer sees no further ops
   function automatic march_t march_at(input logic [ELEM_W-1:0] e);
      return (e <= LAST_ELEM) ? MARCH[e] : '0;
   endfunction

endpackage

// File: rtl/mem_1rw_bist.sv
// mem_1rw_bist: March C- BIST initiator for a single-port 1RW memory
module mem_1rw_bist
   import mem_bist_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [ELEM_W-1:0]     fail_elem,
   output logic [ADDR_WIDTH-1:0] RW0_addr,
   output logic                  RW0_en,
   output logic                  RW0_wmode,
   output logic [DATA_WIDTH-1:0] RW0_wdata,
   input  logic [DATA_WIDTH-1:0] RW0_rdata
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

   state_e                state_q;
   logic [ELEM_W-1:0]     elem_q, elem_d, cur_elem, op_elem_q, rd_elem_q;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, cur_addr, rd_addr_q;
   logic                  phase_q, phase_d, cur_phase;
   logic                  op_exp_q, rd_exp_q, rd_v_q;
   logic                  launch, cur_read, issue, mismatch;
   march_t                cur_m, nxt_m;

   // Pick the op for this edge (restart position on launch) and the position that follows it
   always_comb begin
      launch    = start && (state_q == S_IDLE || state_q == S_DONE);
      cur_elem  = launch ? '0 : elem_q;
      cur_m     = march_at(cur_elem);
      nxt_m     = march_at(cur_elem + ELEM_W'(1));
      cur_addr  = launch ? (cur_m.desc ? ADDR_MAX : '0) : addr_q;
      cur_phase = launch ? 1'b0 : phase_q;
      cur_read  = cur_m.has_read && !cur_phase;
      mismatch  = rd_v_q && (RW0_rdata != {DATA_WIDTH{rd_exp_q}})
                  && (state_q == S_RUN || state_q == S_DRAIN);
      issue     = launch || (state_q == S_RUN && !mismatch && elem_q <= LAST_ELEM);
      elem_d    = cur_elem;
      addr_d    = cur_addr;
      phase_d   = 1'b0;
      if (cur_read && cur_m.has_write)
         phase_d = 1'b1;
      else if (cur_addr == (cur_m.desc ? '0 : ADDR_MAX)) begin
         elem_d = cur_elem + ELEM_W'(1);
         addr_d = nxt_m.desc ? ADDR_MAX : '0;
      end else
         addr_d = cur_m.desc ? cur_addr - ADDR_WIDTH'(1) : cur_addr + ADDR_WIDTH'(1);
   end

   // Sequencer: state, March position, registered RW0 drive and the one-stage read-compare pipeline
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         elem_q    <= '0;
         addr_q    <= '0;
         phase_q   <= 1'b0;
         op_elem_q <= '0;
         op_exp_q  <= 1'b0;
         rd_v_q    <= 1'b0;
         rd_exp_q  <= 1'b0;
         rd_addr_q <= '0;
         rd_elem_q <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fail      <= 1'b0;
         fail_addr <= '0;
         fail_elem <= '0;
         RW0_en    <= 1'b0;
         RW0_wmode <= 1'b0;
         RW0_addr  <= '0;
         RW0_wdata <= '0;
      end else begin
         rd_v_q    <= RW0_en && !RW0_wmode;
         rd_addr_q <= RW0_addr;
         rd_elem_q <= op_elem_q;
         rd_exp_q  <= op_exp_q;
         RW0_en    <= issue;
         RW0_wmode <= issue && !cur_read;
         RW0_addr  <= issue ? cur_addr : '0;
         RW0_wdata <= (issue && !cur_read) ? {DATA_WIDTH{cur_m.write_val}} : '0;
         if (issue) begin
            op_elem_q <= cur_elem;
            op_exp_q  <= cur_m.read_val;
            elem_q    <= elem_d;
            addr_q    <= addr_d;
            phase_q   <= phase_d;
         end
         if (launch) begin
            state_q   <= S_RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
         end else if (mismatch) begin
            state_q   <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_addr <= rd_addr_q;
            fail_elem <= rd_elem_q;
         end else if (state_q == S_DRAIN) begin
            state_q <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
         end else if (state_q == S_RUN && elem_q > LAST_ELEM)
            state_q <= S_DRAIN;
      end
   end

endmodule
